// File: rtl/fir_pe_seq.sv
// rtl/fir_pe_seq.sv - word-stream sequencer for one nibble-serial fir_pe tap
//
// Purpose:
//   Accepts samples on a valid/ready stream and issues each one to the tap as
//   a FRAME_LEN-clock nibble frame that starts with a pe_Rdy strobe. It then
//   collects the Vld-framed pe_Yout nibbles from the tap and reassembles them
//   into results on a single-entry valid/ready output buffer.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   coef_we, coef_in    coefficient shadow write (write-through at accept)
//   s_data/valid/ready  sample input stream
//   m_data/valid/ready  reassembled result output
//   pe_Cin/Xin/Yin/Rdy  registered drive to the tap (pe_Yin fixed at 0)
//   pe_Yout, pe_Vld     result nibbles and frame start from the tap
//   clear               synchronous clear of the sticky flags
//   busy                issue FSM active or frames still pending
//   overflow, timeout   sticky: result dropped / Vld missing too long
module fir_pe_seq #(
    parameter int X_NIB       = 2,
    parameter int Y_NIB       = 4,
    parameter int FRAME_LEN   = 4,
    parameter int MAX_PEND    = 4,
    parameter int VLD_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 coef_we,
    input  logic [5:0]           coef_in,
    input  logic [4*X_NIB-1:0]   s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [4*Y_NIB-1:0]   m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [5:0]           pe_Cin,
    output logic [3:0]           pe_Xin,
    output logic [3:0]           pe_Yin,
    output logic                 pe_Rdy,
    input  logic [3:0]           pe_Yout,
    input  logic                 pe_Vld,
    input  logic                 clear,
    output logic                 busy,
    output logic                 overflow,
    output logic                 timeout
);

    localparam int SW = 4 * X_NIB;
    localparam int RW = 4 * Y_NIB;
    localparam int KW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int CW = (Y_NIB > 1) ? $clog2(Y_NIB) : 1;
    localparam int PW = $clog2(MAX_PEND + 1);
    localparam int TW = $clog2(VLD_TIMEOUT + 1);

    typedef enum logic {IDLE, RUN} issue_t;
    typedef enum logic {CIDLE, COLLECT} cap_t;

    issue_t          istate;
    logic [KW-1:0]   k;
    logic [SW-1:0]   samp;
    logic [5:0]      coef_shadow;
    logic [PW-1:0]   pend;
    logic [TW-1:0]   tcnt;

    cap_t            cstate;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   acc;

    logic            last_k;
    logic            accept;
    logic [3:0]      next_nib;

    logic            cap_take;
    logic [CW-1:0]   cur_idx;
    logic            cap_done;
    logic [RW-1:0]   cap_word;

    logic            load_ok;
    logic            ovf_set;
    logic            dec;
    logic            tmo_fire;

    // The tap is the first in the chain, so its partial-sum input is zero.
    assign pe_Yin = 4'd0;

    assign last_k  = (k == KW'(FRAME_LEN - 1));
    assign s_ready = ((istate == IDLE) || ((istate == RUN) && last_k)) &&
                     (pend < PW'(MAX_PEND));
    assign accept  = s_valid && s_ready;
    assign busy    = (istate != IDLE) || (pend != '0);

    // Nibble for frame position k+1; positions past the sample width carry 0.
    always_comb begin
        next_nib = 4'd0;
        for (int i = 0; i < X_NIB; i++) begin
            if (i == int'(k) + 1) begin
                next_nib = samp[4*i +: 4];
            end
        end
    end

    // Coefficient shadow: writable any cycle, only sampled at frame accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_shadow <= 6'd0;
        end else if (coef_we) begin
            coef_shadow <= coef_in;
        end
    end

    // Issue FSM. An accept at the last frame clock restarts at k=0 so frames
    // run back-to-back with no idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            istate <= IDLE;
            k      <= '0;
            samp   <= '0;
            pe_Cin <= 6'd0;
            pe_Xin <= 4'd0;
            pe_Rdy <= 1'b0;
        end else if (accept) begin
            istate <= RUN;
            k      <= '0;
            samp   <= s_data;
            pe_Cin <= coef_we ? coef_in : coef_shadow;
            pe_Xin <= s_data[3:0];
            pe_Rdy <= 1'b1;
        end else if ((istate == RUN) && !last_k) begin
            k      <= k + KW'(1);
            pe_Xin <= next_nib;
            pe_Rdy <= 1'b0;
        end else begin
            istate <= IDLE;
            k      <= '0;
            pe_Xin <= 4'd0;
            pe_Rdy <= 1'b0;
        end
    end

    // Capture: pe_Vld is only honoured in CIDLE; nibbles arrive LSB first.
    assign cap_take = ((cstate == CIDLE) && pe_Vld) || (cstate == COLLECT);
    assign cur_idx  = (cstate == CIDLE) ? '0 : cnt;
    assign cap_done = cap_take && (cur_idx == CW'(Y_NIB - 1));

    // Word as it stands after the current nibble; a new frame starts from 0.
    always_comb begin
        cap_word = '0;
        for (int i = 0; i < Y_NIB; i++) begin
            if (i == int'(cur_idx)) begin
                cap_word[4*i +: 4] = pe_Yout;
            end else if (cstate == COLLECT) begin
                cap_word[4*i +: 4] = acc[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cstate <= CIDLE;
            cnt    <= '0;
            acc    <= '0;
        end else if (cap_take) begin
            acc <= cap_word;
            if (cap_done) begin
                cstate <= CIDLE;
                cnt    <= '0;
            end else begin
                cstate <= COLLECT;
                cnt    <= cur_idx + CW'(1);
            end
        end
    end

    // Output buffer: a completing result reloads when the buffer is empty or
    // being drained this cycle; otherwise it is dropped and flagged.
    assign load_ok  = !m_valid || m_ready;
    assign ovf_set  = cap_done && !load_ok;
    assign dec      = cap_done && (pend != '0);
    assign tmo_fire = !pe_Vld && (pend != '0) && (tcnt == TW'(VLD_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
        end else if (cap_done && load_ok) begin
            m_data  <= cap_word;
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Pending-frame count and Vld watchdog. A timeout abandons every pending
    // frame, but a frame accepted in that same cycle is still outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            tcnt <= '0;
        end else begin
            if (tmo_fire) begin
                pend <= PW'(accept);
            end else begin
                pend <= pend + PW'(accept) - PW'(dec);
            end

            if (pe_Vld || (pend == '0) || tmo_fire) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    // Sticky flags: a set event in the same cycle as clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            overflow <= ovf_set  || (overflow && !clear);
            timeout  <= tmo_fire || (timeout && !clear);
        end
    end

endmodule

// File: tb/tb_fir_pe_seq.sv
// tb/tb_fir_pe_seq.sv - self-checking bench for fir_pe_seq
module tb_fir_pe_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        coef_we;
    logic [5:0]  coef_in;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [5:0]  pe_Cin;
    logic [3:0]  pe_Xin;
    logic [3:0]  pe_Yin;
    logic        pe_Rdy;
    logic [3:0]  pe_Yout;
    logic        pe_Vld;
    logic        clear;
    logic        busy;
    logic        overflow;
    logic        timeout;

    int n_cmp = 0;
    int n_bad = 0;

    fir_pe_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .coef_we  (coef_we),
        .coef_in  (coef_in),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .pe_Cin   (pe_Cin),
        .pe_Xin   (pe_Xin),
        .pe_Yin   (pe_Yin),
        .pe_Rdy   (pe_Rdy),
        .pe_Yout  (pe_Yout),
        .pe_Vld   (pe_Vld),
        .clear    (clear),
        .busy     (busy),
        .overflow (overflow),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [7:0]  sd;
        logic        cwe;
        logic [5:0]  ci;
        logic        vld;
        logic [3:0]  yo;
        logic        mr;
        logic        e_rdy;
        logic [3:0]  e_xin;
        logic [5:0]  e_cin;
        logic        e_mv;
        logic [15:0] e_md;
        logic        e_sr;
        logic        e_busy;
    } vec_t;

    vec_t tbl [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        coef_we = 1'b0;
        coef_in = 6'd0;
        s_data  = 8'd0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        pe_Yout = 4'd0;
        pe_Vld  = 1'b0;
        clear   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic fill_table();
        //            sv  sd     cwe ci     vld yo    mr    rdy xin   cin    mv  md        sr  busy
        tbl[0]  = '{1'b0, 8'h00, 1'b1, 6'h15, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 6'h00, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 8'hA7, 1'b0, 6'h00, 1'b0, 4'h0, 1'b0, 1'b1, 4'h7, 6'h15, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 6'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'hA, 6'h15, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 6'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 6'h15, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 6'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 6'h15, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 6'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 6'h15, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 6'h00, 1'b1, 4'h4, 1'b1, 1'b0, 4'h0, 6'h15, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 6'h00, 1'b0, 4'h3, 1'b1, 1'b0, 4'h0, 6'h15, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 6'h00, 1'b0, 4'h2, 1'b1, 1'b0, 4'h0, 6'h15, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 6'h00, 1'b0, 4'h1, 1'b1, 1'b0, 4'h0, 6'h15, 1'b1, 16'h1234, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 6'h00, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 6'h15, 1'b0, 16'h0000, 1'b1, 1'b0};
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 11; i++) begin
            s_valid = tbl[i].sv;
            s_data  = tbl[i].sd;
            coef_we = tbl[i].cwe;
            coef_in = tbl[i].ci;
            pe_Vld  = tbl[i].vld;
            pe_Yout = tbl[i].yo;
            m_ready = tbl[i].mr;
            tick();
            chk($sformatf("%s row%0d pe_Rdy", tag, i), 32'(pe_Rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("%s row%0d pe_Xin", tag, i), 32'(pe_Xin), 32'(tbl[i].e_xin));
            chk($sformatf("%s row%0d pe_Cin", tag, i), 32'(pe_Cin), 32'(tbl[i].e_cin));
            chk($sformatf("%s row%0d pe_Yin", tag, i), 32'(pe_Yin), 32'd0);
            chk($sformatf("%s row%0d m_valid", tag, i), 32'(m_valid), 32'(tbl[i].e_mv));
            if (tbl[i].e_mv) begin
                chk($sformatf("%s row%0d m_data", tag, i), 32'(m_data), 32'(tbl[i].e_md));
            end
            chk($sformatf("%s row%0d s_ready", tag, i), 32'(s_ready), 32'(tbl[i].e_sr));
            chk($sformatf("%s row%0d busy", tag, i), 32'(busy), 32'(tbl[i].e_busy));
        end
        idle_inputs();
    endtask

    task automatic send_result(input logic [15:0] v, input logic last_mr, input logic last_clr);
        for (int n = 0; n < 4; n++) begin
            pe_Vld  = (n == 0);
            pe_Yout = v[4*n +: 4];
            m_ready = (n == 3) ? last_mr : 1'b0;
            clear   = (n == 3) ? last_clr : 1'b0;
            tick();
        end
        pe_Vld  = 1'b0;
        pe_Yout = 4'd0;
        m_ready = 1'b0;
        clear   = 1'b0;
    endtask

    initial begin
        fill_table();
        do_reset();

        // Reset state
        chk("rst pe_Cin", 32'(pe_Cin), 32'd0);
        chk("rst pe_Xin", 32'(pe_Xin), 32'd0);
        chk("rst pe_Rdy", 32'(pe_Rdy), 32'd0);
        chk("rst pe_Yin", 32'(pe_Yin), 32'd0);
        chk("rst m_valid", 32'(m_valid), 32'd0);
        chk("rst m_data", 32'(m_data), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst timeout", 32'(timeout), 32'd0);
        chk("rst s_ready", 32'(s_ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);

        // Single frame plus result reassembly
        run_table("t1");

        // Back-to-back frames until MAX_PEND, then Vld timeout
        do_reset();
        s_valid = 1'b1;
        s_data  = 8'h5C;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("b2b e%0d pe_Rdy", i), 32'(pe_Rdy), 32'((i % 4) == 0));
            chk($sformatf("b2b e%0d pe_Xin", i), 32'(pe_Xin),
                ((i % 4) == 0) ? 32'hC : (((i % 4) == 1) ? 32'h5 : 32'h0));
            chk($sformatf("b2b e%0d s_ready", i), 32'(s_ready), 32'(((i % 4) == 3) && (i < 15)));
        end
        tick();
        chk("b2b e16 pe_Rdy", 32'(pe_Rdy), 32'd0);
        chk("b2b e16 s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        for (int i = 17; i < 64; i++) begin
            tick();
        end
        chk("tmo before", 32'(timeout), 32'd0);
        chk("tmo busy before", 32'(busy), 32'd1);
        tick();
        chk("tmo set", 32'(timeout), 32'd1);
        chk("tmo busy", 32'(busy), 32'd0);
        chk("tmo s_ready", 32'(s_ready), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("tmo clear", 32'(timeout), 32'd0);

        // Output buffer hold, overflow, same-cycle reload, clear priority
        do_reset();
        send_result(16'hBEEF, 1'b0, 1'b0);
        chk("ob1 m_valid", 32'(m_valid), 32'd1);
        chk("ob1 m_data", 32'(m_data), 32'hBEEF);
        chk("ob1 overflow", 32'(overflow), 32'd0);
        send_result(16'h0042, 1'b0, 1'b0);
        chk("ob2 m_valid", 32'(m_valid), 32'd1);
        chk("ob2 m_data held", 32'(m_data), 32'hBEEF);
        chk("ob2 overflow", 32'(overflow), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ob clear overflow", 32'(overflow), 32'd0);
        chk("ob clear m_valid", 32'(m_valid), 32'd1);
        send_result(16'hC0DE, 1'b1, 1'b0);
        chk("ob3 reload m_valid", 32'(m_valid), 32'd1);
        chk("ob3 reload m_data", 32'(m_data), 32'hC0DE);
        chk("ob3 overflow", 32'(overflow), 32'd0);
        send_result(16'h0D0D, 1'b0, 1'b1);
        chk("ob4 set beats clear", 32'(overflow), 32'd1);
        chk("ob4 m_data", 32'(m_data), 32'hC0DE);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("ob drain m_valid", 32'(m_valid), 32'd0);
        chk("ob pend sat busy", 32'(busy), 32'd0);

        // Coefficient write during a running frame
        do_reset();
        coef_we = 1'b1;
        coef_in = 6'h15;
        tick();
        coef_we = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h33;
        tick();
        s_valid = 1'b0;
        chk("coef k0", 32'(pe_Cin), 32'h15);
        tick();
        coef_we = 1'b1;
        coef_in = 6'h3F;
        tick();
        coef_we = 1'b0;
        chk("coef k2 unchanged", 32'(pe_Cin), 32'h15);
        tick();
        chk("coef k3 unchanged", 32'(pe_Cin), 32'h15);
        s_valid = 1'b1;
        s_data  = 8'h44;
        tick();
        s_valid = 1'b0;
        chk("coef next frame", 32'(pe_Cin), 32'h3F);
        chk("coef next rdy", 32'(pe_Rdy), 32'd1);
        tick();
        tick();
        tick();
        s_valid = 1'b1;
        s_data  = 8'h55;
        coef_we = 1'b1;
        coef_in = 6'h0A;
        tick();
        idle_inputs();
        chk("coef write-through", 32'(pe_Cin), 32'h0A);

        // Asynchronous reset in the middle of a frame
        do_reset();
        coef_we = 1'b1;
        coef_in = 6'h15;
        tick();
        coef_we = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hA7;
        tick();
        s_valid = 1'b0;
        tick();
        chk("mid k1 pe_Xin", 32'(pe_Xin), 32'hA);
        rst_n = 1'b0;
        #2;
        chk("mid rst pe_Cin", 32'(pe_Cin), 32'd0);
        chk("mid rst pe_Xin", 32'(pe_Xin), 32'd0);
        chk("mid rst pe_Rdy", 32'(pe_Rdy), 32'd0);
        chk("mid rst m_valid", 32'(m_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid after m_valid", 32'(m_valid), 32'd0);
        run_table("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
